mux_n_to_1_arb: RTL and testbench
=================================

Name: mux_n_to_1_arb

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Two selection modes: manual (external select, the 4-to-1 mux behaviour generalised) and round-robin (fair scan of requesting channels).
- Sits between several producer channels and one downstream consumer.
- One output register stage.

Parameters:
- NCH, 4, number of input channels (2..16).
- WIDTH, 1, data width per channel in bits.
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= NCH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel data valid.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- mode  input  1  0 = manual select, 1 = round-robin.
- sel  input  SELW  channel index used in manual mode.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data.
- sel_err  output  1  registered one-cycle pulse: manual mode with sel >= NCH.

Behaviour:
- Reset, synchronous and active-high, sampled on the rising edge of clock. Effects:
  - out_valid=0, out_data=0, out_chan=0, sel_err=0.
  - Round-robin pointer last=NCH-1, so the first scan starts at channel 0.
- Reset mid-operation: a held output word is dropped. in_ready is 0 while reset is high.
- Output stage can load: load_ok = !out_valid || out_ready.
- Grant (combinational, every cycle):
  - Manual (mode=0): grant channel sel when sel < NCH and in_valid[sel]=1. Otherwise no grant.
  - Round-robin (mode=1): grant the first k with in_valid[k]=1, searching k = last+1, last+2, ... modulo NCH. The search wraps from NCH-1 to 0 and includes last as the final candidate. No grant if no valid.
- Handshake and transfer:
  - in_ready[g] = load_ok && grant && (g == granted index). All other in_ready bits are 0.
  - Transfer occurs when in_valid[g] && in_ready[g].
  - On the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - In round-robin mode, last <= g on transfer only.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous output drain and new load in the same cycle is allowed.
- Stall (out_valid=1, out_ready=0): out_data and out_chan are held stable and all in_ready=0.
- Output emptying: when out_valid && out_ready with no transfer, out_valid <= 0. out_data and out_chan hold their last value.
- Mode and sel may change on any cycle and are sampled combinationally. A mode change does not reset last. A word already in the output register is unaffected.
- sel_err: sel_err <= (mode==0 && sel >= NCH), registered every cycle, independent of in_valid. It is not sticky. It is never asserted in round-robin mode.
- Producer rule: in_valid must stay high and data stable until accepted. The block does not check this rule.
- NCH not a power of two: indices >= NCH are never granted and never appear on out_chan.

Test Plan:
1. Manual select, NCH=4, WIDTH=8, out_ready=1:
   - Stimulus: in_data ch0..3 = 8'hA0, A1, A2, A3, all valid; sel steps 0,1,2,3 on consecutive cycles.
   - Required: out_data = A0, A1, A2, A3 one cycle after each select; out_chan = 0..3; only the in_ready of the selected channel pulses.
2. Round-robin fairness, all four channels valid continuously, out_ready=1:
   - Required: out_chan sequence 0,1,2,3,0,1 with out_valid continuously 1 after the first cycle.
   - Then drop ch1 valid. Required: sequence ...,3,0,2,3,0 (ch1 skipped).
3. Back-pressure:
   - Stimulus: out_ready=0 after the first word (ch2 = 8'h5C) is loaded; hold for 5 cycles.
   - Required: out_data=8'h5C, out_chan=2, out_valid=1 stable; in_ready=4'b0000 throughout.
   - Then out_ready=1. Required: the next granted word appears on the following cycle with no bubble.
4. Invalid select, NCH=3, SELW=2, mode=0:
   - Stimulus: sel=3 with all channels valid.
   - Required: sel_err=1 on the next cycle, in_ready=0, out_valid falls to 0 after the drain.
   - Then sel=1. Required: sel_err=0 and ch1 data appears.
5. Reset mid-operation:
   - Stimulus: word held with out_valid=1 and out_ready=0; assert reset for 1 cycle with all channels valid, mode=1.
   - Required: out_valid=0 and out_data=0 the cycle after reset; the first post-reset grant is ch0.
6. Wrap and mode switch:
   - Stimulus: round-robin with last=3 and only ch3 valid, so ch3 is re-granted.
   - Then switch to mode=0 with sel=1 and ch1 valid. Required: ch1 is granted the next cycle.
   - Then return to mode=1 with all channels valid. Required: scan resumes from channel 0 (last=3 preserved).

Source files
------------

// File: rtl/mux_n_to_1_arb.sv
// N-channel registered mux: manual select or round-robin grant; 1-cycle latency in->out.
// Backpressure: a stalled output word holds and all in_ready drop; drain+load same cycle allowed.
module mux_n_to_1_arb #(
  parameter int NCH   = 4,
  parameter int WIDTH = 1,
  parameter int SELW  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  localparam logic [SELW:0]   NCH_W    = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_RST = SELW'(NCH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             sel_ok;
  logic             man_vld;
  logic             rr_vld;
  logic [SELW-1:0]  rr_idx;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_dat;
  logic             load_ok;
  logic             xfer;

  assign sel_ok  = ({1'b0, sel} < NCH_W);
  assign load_ok = !out_valid_q || out_ready;

  // Manual grant: compare against every legal index so an out-of-range sel never indexes in_valid.
  always_comb begin
    man_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_ok && (sel == SELW'(k)) && in_valid[k]) begin
        man_vld = 1'b1;
      end
    end
  end

  // Round-robin: scan last+1 .. last+NCH (mod NCH); last itself is the final candidate.
  always_comb begin
    int cand;
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int d = 1; d <= NCH; d++) begin
      cand = int'(last_q) + d;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      for (int k = 0; k < NCH; k++) begin
        if (!rr_vld && (k == cand) && in_valid[k]) begin
          rr_vld = 1'b1;
          rr_idx = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_vld = mode ? rr_vld : man_vld;
    gnt_idx = mode ? rr_idx : sel;
  end

  assign xfer = gnt_vld && load_ok && !reset;

  always_comb begin
    gnt_dat  = '0;
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == SELW'(k)) begin
        gnt_dat     = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = xfer;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    sel_err_d   = !mode && !sel_ok;
    if (xfer) begin
      out_data_d  = gnt_dat;
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        last_d = gnt_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// Directed bench for mux_n_to_1_arb: a 4-channel and a 3-channel instance share clock and reset.
module tb_mux_n_to_1_arb;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic        mode4, out_valid4, out_ready4, sel_err4;
  logic [1:0]  sel4, out_chan4;
  logic [7:0]  out_data4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic        mode3, out_valid3, out_ready3, sel_err3;
  logic [1:0]  sel3, out_chan3;
  logic [7:0]  out_data3;

  int n_pass  = 0;
  int n_total = 0;

  mux_n_to_1_arb #(.NCH(4), .WIDTH(8), .SELW(2)) u_dut4 (
    .clock(clock), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
    .out_chan(out_chan4), .out_valid(out_valid4), .out_ready(out_ready4), .sel_err(sel_err4)
  );

  mux_n_to_1_arb #(.NCH(3), .WIDTH(8), .SELW(2)) u_dut3 (
    .clock(clock), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid4 = 4'hF; mode4 = 1'b1; out_ready4 = 1'b1;
    in_valid3 = 3'h7; mode3 = 1'b1; out_ready3 = 1'b1;
    tick();
    tick();
    n_total++; if (out_valid4 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid4); else n_pass++;
    n_total++; if (out_data4 !== 8'h00) $display("FAIL rst_out_data: got %h want 00", out_data4); else n_pass++;
    n_total++; if (out_chan4 !== 2'd0) $display("FAIL rst_out_chan: got %0d want 0", out_chan4); else n_pass++;
    n_total++; if (sel_err4 !== 1'b0) $display("FAIL rst_sel_err: got %b want 0", sel_err4); else n_pass++;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0000) $display("FAIL rst_in_ready4: got %b want 0000", in_ready4); else n_pass++;
    n_total++; if (in_ready3 !== 3'b000) $display("FAIL rst_in_ready3: got %b want 000", in_ready3); else n_pass++;
    tick();
    reset = 1'b0;
    in_valid4 = 4'h0; mode4 = 1'b0;
    in_valid3 = 3'h0; mode3 = 1'b0;
    tick();
  endtask

  task automatic test_manual;
    logic [3:0] exp_rdy;
    mode4 = 1'b0; out_ready4 = 1'b1; in_valid4 = 4'hF;
    in_data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      exp_rdy = 4'b0001 << s;
      @(negedge clock);
      n_total++; if (in_ready4 !== exp_rdy) $display("FAIL man_in_ready[%0d]: got %b want %b", s, in_ready4, exp_rdy); else n_pass++;
      tick();
      n_total++; if (out_data4 !== 8'(8'hA0 + s)) $display("FAIL man_data[%0d]: got %h want %h", s, out_data4, 8'(8'hA0 + s)); else n_pass++;
      n_total++; if (out_chan4 !== 2'(s) || out_valid4 !== 1'b1) $display("FAIL man_chan[%0d]: got %0d/%b want %0d/1", s, out_chan4, out_valid4, s); else n_pass++;
    end
    in_valid4 = 4'h0;
    tick();
  endtask

  task automatic test_round_robin;
    int exp_a[6] = '{0, 1, 2, 3, 0, 1};
    int exp_b[6] = '{2, 3, 0, 2, 3, 0};
    do_reset();
    mode4 = 1'b1; out_ready4 = 1'b1; in_valid4 = 4'hF;
    in_data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (out_chan4 !== 2'(exp_a[i]) || out_valid4 !== 1'b1) $display("FAIL rr_all[%0d]: got %0d/%b want %0d/1", i, out_chan4, out_valid4, exp_a[i]); else n_pass++;
    end
    in_valid4 = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (out_chan4 !== 2'(exp_b[i]) || out_valid4 !== 1'b1) $display("FAIL rr_skip1[%0d]: got %0d/%b want %0d/1", i, out_chan4, out_valid4, exp_b[i]); else n_pass++;
      n_total++; if (out_data4 !== 8'(8'hA0 + exp_b[i])) $display("FAIL rr_skip1_data[%0d]: got %h want %h", i, out_data4, 8'(8'hA0 + exp_b[i])); else n_pass++;
    end
    in_valid4 = 4'h0;
    tick();
  endtask

  task automatic test_back_pressure;
    do_reset();
    mode4 = 1'b0; sel4 = 2'd2; out_ready4 = 1'b1;
    in_data4 = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
    in_valid4 = 4'b0100;
    tick();
    n_total++; if (out_data4 !== 8'h5C || out_valid4 !== 1'b1) $display("FAIL bp_first: got %h/%b want 5c/1", out_data4, out_valid4); else n_pass++;
    out_ready4 = 1'b0;
    in_data4[23:16] = 8'h6E;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_total++; if (in_ready4 !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready4); else n_pass++;
      tick();
      n_total++; if (out_data4 !== 8'h5C || out_chan4 !== 2'd2 || out_valid4 !== 1'b1) $display("FAIL bp_hold[%0d]: got %h/%0d/%b want 5c/2/1", i, out_data4, out_chan4, out_valid4); else n_pass++;
    end
    out_ready4 = 1'b1;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0100) $display("FAIL bp_release_rdy: got %b want 0100", in_ready4); else n_pass++;
    tick();
    n_total++; if (out_data4 !== 8'h6E || out_chan4 !== 2'd2 || out_valid4 !== 1'b1) $display("FAIL bp_no_bubble: got %h/%0d/%b want 6e/2/1", out_data4, out_chan4, out_valid4); else n_pass++;
    in_valid4 = 4'h0;
    tick();
    n_total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'h6E) $display("FAIL bp_drain: got %h/%b want 6e/0", out_data4, out_valid4); else n_pass++;
  endtask

  task automatic test_invalid_sel;
    int exp_c[4] = '{0, 1, 2, 0};
    do_reset();
    mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b111;
    in_data3 = {8'hC2, 8'hC1, 8'hC0};
    tick();
    n_total++; if (out_data3 !== 8'hC0 || out_valid3 !== 1'b1) $display("FAIL inv_pre: got %h/%b want c0/1", out_data3, out_valid3); else n_pass++;
    sel3 = 2'd3;
    @(negedge clock);
    n_total++; if (in_ready3 !== 3'b000) $display("FAIL inv_in_ready: got %b want 000", in_ready3); else n_pass++;
    tick();
    n_total++; if (sel_err3 !== 1'b1) $display("FAIL inv_sel_err: got %b want 1", sel_err3); else n_pass++;
    n_total++; if (out_valid3 !== 1'b0 || out_data3 !== 8'hC0) $display("FAIL inv_drain: got %h/%b want c0/0", out_data3, out_valid3); else n_pass++;
    sel3 = 2'd1;
    @(negedge clock);
    n_total++; if (in_ready3 !== 3'b010) $display("FAIL inv_recover_rdy: got %b want 010", in_ready3); else n_pass++;
    tick();
    n_total++; if (sel_err3 !== 1'b0) $display("FAIL inv_sel_err_clear: got %b want 0", sel_err3); else n_pass++;
    n_total++; if (out_data3 !== 8'hC1 || out_chan3 !== 2'd1 || out_valid3 !== 1'b1) $display("FAIL inv_recover: got %h/%0d/%b want c1/1/1", out_data3, out_chan3, out_valid3); else n_pass++;
    mode3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (out_chan3 !== 2'(exp_c[i]) || sel_err3 !== 1'b0) $display("FAIL rr3[%0d]: got %0d/%b want %0d/0", i, out_chan3, sel_err3, exp_c[i]); else n_pass++;
    end
    in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0;
    tick();
  endtask

  task automatic test_reset_mid_op;
    mode4 = 1'b1; out_ready4 = 1'b1; in_valid4 = 4'hF;
    in_data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    out_ready4 = 1'b0;
    tick();
    n_total++; if (out_valid4 !== 1'b1) $display("FAIL mid_held: got %b want 1", out_valid4); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0000) $display("FAIL mid_rst_rdy: got %b want 0000", in_ready4); else n_pass++;
    tick();
    n_total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'h00) $display("FAIL mid_dropped: got %h/%b want 00/0", out_data4, out_valid4); else n_pass++;
    reset = 1'b0; out_ready4 = 1'b1;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0001) $display("FAIL mid_first_rdy: got %b want 0001", in_ready4); else n_pass++;
    tick();
    n_total++; if (out_chan4 !== 2'd0 || out_data4 !== 8'hA0 || out_valid4 !== 1'b1) $display("FAIL mid_first_grant: got %0d/%h/%b want 0/a0/1", out_chan4, out_data4, out_valid4); else n_pass++;
  endtask

  task automatic test_wrap_mode_switch;
    do_reset();
    mode4 = 1'b1; out_ready4 = 1'b1; in_valid4 = 4'b1000;
    in_data4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    n_total++; if (out_chan4 !== 2'd3 || out_data4 !== 8'hA3) $display("FAIL wrap_first: got %0d/%h want 3/a3", out_chan4, out_data4); else n_pass++;
    tick();
    n_total++; if (out_chan4 !== 2'd3 || out_valid4 !== 1'b1) $display("FAIL wrap_regrant: got %0d/%b want 3/1", out_chan4, out_valid4); else n_pass++;
    mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b0010;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0010) $display("FAIL switch_man_rdy: got %b want 0010", in_ready4); else n_pass++;
    tick();
    n_total++; if (out_chan4 !== 2'd1 || out_data4 !== 8'hA1) $display("FAIL switch_man: got %0d/%h want 1/a1", out_chan4, out_data4); else n_pass++;
    mode4 = 1'b1; in_valid4 = 4'hF;
    @(negedge clock);
    n_total++; if (in_ready4 !== 4'b0001) $display("FAIL switch_rr_rdy: got %b want 0001", in_ready4); else n_pass++;
    tick();
    n_total++; if (out_chan4 !== 2'd0 || out_data4 !== 8'hA0) $display("FAIL switch_rr: got %0d/%h want 0/a0", out_chan4, out_data4); else n_pass++;
    in_valid4 = 4'h0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_data4 = '0; in_valid4 = '0; mode4 = 1'b0; sel4 = '0; out_ready4 = 1'b0;
    in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
    test_reset();
    test_manual();
    test_round_robin();
    test_back_pressure();
    test_invalid_sel();
    test_reset_mid_op();
    test_wrap_mode_switch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
